// File: rtl/cfu_l1_arbiter_pkg.sv
// Shared types for the CFU-L1 arbiter: response status codes and the
// in-flight tag that routes each response back to its originator.
package cfu_l1_arbiter_pkg;

    typedef enum logic [2:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_FUNC   = 3'd1,
        CFU_ERROR_STATE  = 3'd2,
        CFU_ERROR_CUSTOM = 3'd3
    } cfu_status_t;

    // Wide enough for any practical requester count; upper bits stay zero.
    localparam int ARB_IDX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 lerr;
        logic [ARB_IDX_W-1:0] idx;
    } cfu_arb_tag_t;

endpackage

// File: rtl/cfu_l1_arbiter_if.sv
// Requester-side bus of the CFU-L1 arbiter: N_REQ request lanes with a
// valid/ready handshake and a shared, one-hot-qualified response.
interface cfu_l1_arbiter_if
    import cfu_l1_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int FUNC_ID_W   = 10,
    parameter int DATA_W      = 32,
    parameter int LCL_STATE_W = 4
);
    logic [N_REQ-1:0]                  req_valid;
    logic [N_REQ-1:0]                  req_ready;
    logic [N_REQ-1:0][FUNC_ID_W-1:0]   req_func;
    logic [N_REQ-1:0][LCL_STATE_W-1:0] req_state;
    logic [N_REQ-1:0][DATA_W-1:0]      req_data0;
    logic [N_REQ-1:0][DATA_W-1:0]      req_data1;
    logic [N_REQ-1:0]                  resp_valid;
    cfu_status_t                       resp_status;
    logic [DATA_W-1:0]                 resp_data;

    modport master (
        output req_valid, req_func, req_state, req_data0, req_data1,
        input  req_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_func, req_state, req_data0, req_data1,
        output req_ready, resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/cfu_l1_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid index at or after rr (mod N) wins;
// rr moves just past the winner on every accept.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         valid,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 accept
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // N is a power of two, so the modulo wrap is plain index overflow.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = rr + IDX_W'(k);
            if (!found && valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept = en & found;
    assign grant  = accept ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (accept) begin
            rr <= grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/shift_reg.sv
// Enable-gated delay line of N stages; N=0 degenerates to a wire.
module shift_reg #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (N == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, en};
            assign q = d;
        end else begin : g_reg
            logic [W-1:0] stage [N];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < N; i++) stage[i] <= '0;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[N-1];
        end
    endgenerate
endmodule

// File: rtl/cfu_l1_arbiter.sv
// Shares one fixed-latency CFU among N_REQ requesters: round-robin accept,
// private state-context slices, and tag-routed responses at exactly LATENCY.
module cfu_l1_arbiter
    import cfu_l1_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int LATENCY        = 0,
    parameter int FUNC_ID_W      = 10,
    parameter int DATA_W         = 32,
    parameter int STATES_PER_REQ = 1,
    parameter int LCL_STATE_W    = 4,
    parameter int CFU_STATE_ID_W = ($clog2(N_REQ * STATES_PER_REQ) < 1) ? 1
                                   : $clog2(N_REQ * STATES_PER_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    cfu_l1_arbiter_if.slave           req_bus,
    output logic                      cfu_req_valid,
    output logic [FUNC_ID_W-1:0]      cfu_req_func,
    output logic [CFU_STATE_ID_W-1:0] cfu_req_state,
    output logic [DATA_W-1:0]         cfu_req_data0,
    output logic [DATA_W-1:0]         cfu_req_data1,
    input  logic                      cfu_resp_valid,
    input  cfu_status_t               cfu_resp_status,
    input  logic [DATA_W-1:0]         cfu_resp_data
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]       g;
    logic                   accept;
    logic                   lerr;
    logic [LCL_STATE_W-1:0] win_state;
    cfu_arb_tag_t           tag_in;
    cfu_arb_tag_t           tag_out;
    logic [N_REQ-1:0]       resp_oh;
    cfu_status_t            resp_st;
    logic [DATA_W-1:0]      resp_d;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .valid     (req_bus.req_valid),
        .grant     (req_bus.req_ready),
        .grant_idx (g),
        .accept    (accept)
    );

    // A local index outside the requester's slice is swallowed here so it
    // can never alias into another requester's contexts.
    assign win_state = req_bus.req_state[g];
    assign lerr      = int'(win_state) >= STATES_PER_REQ;

    always_comb begin
        cfu_req_valid = accept & ~lerr;
        cfu_req_func  = '0;
        cfu_req_state = '0;
        cfu_req_data0 = '0;
        cfu_req_data1 = '0;
        if (cfu_req_valid) begin
            cfu_req_func  = req_bus.req_func[g];
            cfu_req_state = CFU_STATE_ID_W'(int'(g) * STATES_PER_REQ + int'(win_state));
            cfu_req_data0 = req_bus.req_data0[g];
            cfu_req_data1 = req_bus.req_data1[g];
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = accept;
        tag_in.lerr  = accept & lerr;
        tag_in.idx   = ARB_IDX_W'(g);
    end

    shift_reg #(.W($bits(cfu_arb_tag_t)), .N(LATENCY)) u_tags (
        .clk (clk),
        .rst (rst),
        .en  (clk_en),
        .d   (tag_in),
        .q   (tag_out)
    );

    // Emerging tag steers the shared response to its originator.
    always_comb begin
        resp_oh = '0;
        resp_st = CFU_OK;
        resp_d  = '0;
        if (tag_out.valid) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (int'(tag_out.idx) == i) resp_oh[i] = tag_out.lerr | cfu_resp_valid;
            end
            if (tag_out.lerr) begin
                resp_st = CFU_ERROR_STATE;
            end else begin
                resp_st = cfu_resp_status;
                resp_d  = cfu_resp_data;
            end
        end
    end

    assign req_bus.resp_valid  = resp_oh;
    assign req_bus.resp_status = resp_st;
    assign req_bus.resp_data   = resp_d;

    a_resp_matches_tag: assert property (@(posedge clk) disable iff (rst)
        cfu_resp_valid == (tag_out.valid && !tag_out.lerr));
endmodule

// File: tb/tb_cfu_l1_arbiter.sv
// Bench for cfu_l1_arbiter with a behavioural CFU (dot product, state
// write/read) and a queue-based reference model of arbitration and routing.
module tb_cfu_l1_arbiter;
    import cfu_l1_arbiter_pkg::*;

    localparam int N_REQ = 4;
    localparam int LATENCY = 3;
    localparam int FUNC_ID_W = 10;
    localparam int DATA_W = 32;
    localparam int SPR = 1;
    localparam int LCL_STATE_W = 4;
    localparam int CSW = 2;
    localparam logic [9:0] F_DOT = 10'd0;
    localparam logic [9:0] F_WR  = 10'd1;
    localparam logic [9:0] F_RD  = 10'd2;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    always #5 clk = ~clk;

    cfu_l1_arbiter_if #(.N_REQ(N_REQ), .FUNC_ID_W(FUNC_ID_W), .DATA_W(DATA_W),
                        .LCL_STATE_W(LCL_STATE_W)) bus ();

    logic              cfu_req_valid;
    logic [9:0]        cfu_req_func;
    logic [CSW-1:0]    cfu_req_state;
    logic [31:0]       cfu_req_data0, cfu_req_data1;
    logic              cfu_resp_valid;
    cfu_status_t       cfu_resp_status;
    logic [31:0]       cfu_resp_data;

    cfu_l1_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY), .FUNC_ID_W(FUNC_ID_W),
                     .DATA_W(DATA_W), .STATES_PER_REQ(SPR),
                     .LCL_STATE_W(LCL_STATE_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .req_bus         (bus),
        .cfu_req_valid   (cfu_req_valid),
        .cfu_req_func    (cfu_req_func),
        .cfu_req_state   (cfu_req_state),
        .cfu_req_data0   (cfu_req_data0),
        .cfu_req_data1   (cfu_req_data1),
        .cfu_resp_valid  (cfu_resp_valid),
        .cfu_resp_status (cfu_resp_status),
        .cfu_resp_data   (cfu_resp_data)
    );

    typedef struct packed {
        logic        v;
        cfu_status_t st;
        logic [31:0] d;
    } cfu_pipe_t;

    function automatic logic [31:0] dot4(logic [31:0] a, logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        return 32'(s);
    endfunction

    function automatic cfu_pipe_t cfu_exec(logic [9:0] f, logic [31:0] st, logic [31:0] a, logic [31:0] b);
        cfu_pipe_t r;
        r.v  = 1'b1;
        r.st = CFU_OK;
        r.d  = '0;
        case (f)
            F_DOT:   r.d = dot4(a, b);
            F_WR:    r.d = '0;
            F_RD:    r.d = st;
            default: r.st = CFU_ERROR_FUNC;
        endcase
        return r;
    endfunction

    // Downstream CFU: fixed latency, advances on clk_en, shares rst.
    cfu_pipe_t   cpipe [LATENCY];
    logic [31:0] cstate [1 << CSW];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) cpipe[i] <= '0;
            for (int j = 0; j < (1 << CSW); j++) cstate[j] <= '0;
        end else if (clk_en) begin
            cpipe[0] <= cfu_req_valid ?
                cfu_exec(cfu_req_func, cstate[cfu_req_state], cfu_req_data0, cfu_req_data1) : '0;
            for (int i = 1; i < LATENCY; i++) cpipe[i] <= cpipe[i-1];
            if (cfu_req_valid && cfu_req_func == F_WR) cstate[cfu_req_state] <= cfu_req_data0;
        end
    end

    assign cfu_resp_valid  = cpipe[LATENCY-1].v;
    assign cfu_resp_status = cpipe[LATENCY-1].st;
    assign cfu_resp_data   = cpipe[LATENCY-1].d;

    // Reference model state
    typedef struct {
        int        due;
        int        idx;
        bit        lerr;
        cfu_pipe_t r;
    } exp_t;

    exp_t        q[$];
    int          rr_m, ecount, g_m;
    bit          acc_m, lerr_m;
    logic [31:0] mstate [N_REQ][SPR];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_func  = '0;
        bus.req_state = '0;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
    endtask

    task automatic set_req(int i, logic [9:0] f, logic [3:0] s, logic [31:0] a, logic [31:0] b);
        bus.req_valid[i] = 1'b1;
        bus.req_func[i]  = f;
        bus.req_state[i] = s;
        bus.req_data0[i] = a;
        bus.req_data1[i] = b;
    endtask

    task automatic settle();
        bit          found;
        int          idx;
        logic [63:0] ev, es, ed;
        #4;
        found = 1'b0;
        g_m   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (rr_m + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                g_m   = idx;
            end
        end
        acc_m  = clk_en && found;
        lerr_m = acc_m && (int'(bus.req_state[g_m]) >= SPR);
        if (rst) return;
        chk("req_ready", 64'(bus.req_ready), acc_m ? 64'(1 << g_m) : 64'(0));
        chk("cfu_req_valid", 64'(cfu_req_valid), 64'(acc_m && !lerr_m));
        if (acc_m && !lerr_m) begin
            chk("cfu_req_state", 64'(cfu_req_state), 64'(g_m * SPR + int'(bus.req_state[g_m])));
            chk("cfu_req_func", 64'(cfu_req_func), 64'(bus.req_func[g_m]));
            chk("cfu_req_data0", 64'(cfu_req_data0), 64'(bus.req_data0[g_m]));
            chk("cfu_req_data1", 64'(cfu_req_data1), 64'(bus.req_data1[g_m]));
        end else begin
            chk("cfu_req_func_idle", 64'(cfu_req_func), 64'(0));
            chk("cfu_req_data_idle", 64'({cfu_req_data0, cfu_req_data1}), 64'(0));
        end
        ev = 64'(0);
        es = 64'(CFU_OK);
        ed = 64'(0);
        if (q.size() > 0 && q[0].due == ecount) begin
            ev = 64'(1 << q[0].idx);
            es = q[0].lerr ? 64'(CFU_ERROR_STATE) : 64'(q[0].r.st);
            ed = q[0].lerr ? 64'(0) : 64'(q[0].r.d);
        end
        chk("resp_valid", 64'(bus.resp_valid), ev);
        chk("resp_status", 64'(bus.resp_status), es);
        chk("resp_data", 64'(bus.resp_data), ed);
    endtask

    task automatic advance();
        exp_t e;
        int   s;
        @(posedge clk);
        if (rst) begin
            rr_m = 0;
            q.delete();
            for (int i = 0; i < N_REQ; i++)
                for (int j = 0; j < SPR; j++) mstate[i][j] = '0;
        end else if (clk_en) begin
            if (q.size() > 0 && q[0].due == ecount) void'(q.pop_front());
            if (acc_m) begin
                e.due  = ecount + LATENCY;
                e.idx  = g_m;
                e.lerr = lerr_m;
                e.r    = '0;
                if (!lerr_m) begin
                    s   = int'(bus.req_state[g_m]);
                    e.r = cfu_exec(bus.req_func[g_m], mstate[g_m][s], bus.req_data0[g_m], bus.req_data1[g_m]);
                    if (bus.req_func[g_m] == F_WR) mstate[g_m][s] = bus.req_data0[g_m];
                end
                q.push_back(e);
                rr_m = (g_m + 1) % N_REQ;
            end
            ecount++;
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        rr_m   = 0;
        ecount = 0;
        clear_reqs();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < SPR; j++) mstate[i][j] = '0;
        #1;
        advance();
        advance();
        rst = 1'b0;

        // Reset, then idle
        settle();
        chk("idle_ready", 64'(bus.req_ready), 64'(0));
        chk("idle_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("idle_resp_status", 64'(bus.resp_status), 64'(CFU_OK));
        chk("idle_resp_data", 64'(bus.resp_data), 64'(0));
        advance();

        // Contention: requesters 0 and 1 issue dotprod every cycle
        set_req(0, F_DOT, 4'd0, 32'h0101_0101, 32'h0202_0202);
        set_req(1, F_DOT, 4'd0, 32'h0101_0101, 32'h0202_0202);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("contend_grant", 64'(bus.req_ready), (i % 2 == 1) ? 64'(2) : 64'(1));
            if (i >= LATENCY) begin
                chk("contend_resp_oh", 64'(bus.resp_valid), ((i - LATENCY) % 2 == 1) ? 64'(2) : 64'(1));
                chk("contend_resp_data", 64'(bus.resp_data), 64'(8));
            end
            advance();
        end

        // State isolation
        clear_reqs();
        set_req(1, F_WR, 4'd0, 32'h55, 32'h0);
        settle();
        chk("iso_wr_state", 64'(cfu_req_state), 64'(1));
        advance();
        clear_reqs();
        set_req(0, F_RD, 4'd0, 32'h0, 32'h0);
        settle();
        chk("iso_rd_state", 64'(cfu_req_state), 64'(0));
        advance();
        clear_reqs();
        step();
        step();
        settle();
        chk("iso_rd_oh", 64'(bus.resp_valid), 64'(1));
        chk("iso_rd_data", 64'(bus.resp_data), 64'(0));
        advance();

        // Local bounds error
        set_req(0, F_DOT, 4'd1, 32'h1234_5678, 32'h1111_1111);
        settle();
        chk("lerr_no_fwd", 64'(cfu_req_valid), 64'(0));
        advance();
        clear_reqs();
        step();
        step();
        settle();
        chk("lerr_oh", 64'(bus.resp_valid), 64'(1));
        chk("lerr_status", 64'(bus.resp_status), 64'(CFU_ERROR_STATE));
        chk("lerr_data", 64'(bus.resp_data), 64'(0));
        advance();

        // clk_en low for 3 cycles mid-pipeline
        set_req(0, F_DOT, 4'd0, 32'h0102_0304, 32'h0101_0101);
        step();
        clear_reqs();
        step();
        clk_en = 1'b0;
        set_req(0, F_DOT, 4'd0, 32'h1, 32'h1);
        set_req(1, F_DOT, 4'd0, 32'h1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_no_grant", 64'(bus.req_ready), 64'(0));
            chk("stall_no_resp", 64'(bus.resp_valid), 64'(0));
            advance();
        end
        clk_en = 1'b1;
        clear_reqs();
        step();
        settle();
        chk("stall_resp_oh", 64'(bus.resp_valid), 64'(1));
        chk("stall_resp_data", 64'(bus.resp_data), 64'(10));
        advance();

        // Reset with two requests in flight
        set_req(0, F_DOT, 4'd0, 32'h0101_0101, 32'h0101_0101);
        set_req(1, F_DOT, 4'd0, 32'h0101_0101, 32'h0101_0101);
        step();
        step();
        clear_reqs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        set_req(0, F_DOT, 4'd0, 32'h2, 32'h3);
        set_req(3, F_DOT, 4'd0, 32'h2, 32'h3);
        settle();
        chk("post_rst_grant", 64'(bus.req_ready), 64'(1));
        chk("post_rst_no_resp", 64'(bus.resp_valid), 64'(0));
        advance();
        clear_reqs();
        settle();
        chk("post_rst_no_resp", 64'(bus.resp_valid), 64'(0));
        advance();
        step();
        step();

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            clk_en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                bus.req_func[i]  = 10'($urandom_range(0, 3));
                bus.req_state[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                bus.req_data0[i] = $urandom();
                bus.req_data1[i] = $urandom();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
